// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel clock-enable, registered sync/de/blank and line/frame strobes
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          vblank,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          line_start,
  output logic          frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] div;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          h_wrap, div_wrap;
  // next raster position; outputs are decoded from it so they stay aligned with the counters
  always_comb begin
    div_wrap = div == DIV_LAST;
    h_wrap   = pix_ce && (h_count == H_LAST);
    h_nxt    = pix_ce ? (h_wrap ? '0 : h_count + CW'(1)) : h_count;
    v_nxt    = h_wrap ? (v_count == V_LAST ? '0 : v_count + CW'(1)) : v_count;
  end
  // divider, position counters and registered decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      de          <= 1'b1;
      vblank      <= 1'b0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      if (en) div <= div_wrap ? '0 : div + DW'(1);
      pix_ce      <= en && div_wrap;
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      de          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      vblank      <= v_nxt >= V_ACT;
      line_start  <= h_nxt == '0;
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
      hsync       <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? HS_POL : ~HS_POL;
      vsync       <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? VS_POL : ~VS_POL;
    end
  end
endmodule
